// File: rtl/tetris_pkg.sv
// Shared board geometry, piece shape table and lock-writer state encoding.
package tetris_pkg;

  localparam int ROWS  = 20;
  localparam int COLS  = 16;
  localparam int CW    = 3;
  localparam int ROW_W = COLS * CW;

  typedef enum logic [3:0] {
    P_I1 = 4'd0, P_I2, P_O, P_S1, P_S2,
    P_J1, P_J2, P_J3, P_J4,
    P_T1, P_T2, P_T3, P_T4,
    P_Z1, P_Z2, P_NONE
  } piece_e;

  // One 16-bit word per piece code: cell k sits in nibble k as {dy[1:0], dx[1:0]}.
  // Shapes are bottom-aligned in the 4x4 box, same geometry as the collision check.
  localparam logic [15:0] PIECE_CELLS [15] = '{
    16'hFEDC,  // I1
    16'hD951,  // I2
    16'hEDA9,  // O
    16'hDCA9,  // S1
    16'hD984,  // S2
    16'hEDC8,  // J1
    16'hD965,  // J2
    16'hEA98,  // J3
    16'hDC95,  // J4
    16'hEDC9,  // T1
    16'hDA95,  // T2
    16'hDA98,  // T3
    16'hD985,  // T4
    16'hED98,  // Z1
    16'hC985   // Z2
  };

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_SCAN  = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } lock_state_e;

  // A row is full when none of its cells holds the empty code.
  function automatic logic row_full(input logic [ROW_W-1:0] row);
    logic full;
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (row[c*CW +: CW] == '0) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/piece_cell_rom.sv
// Combinational lookup of one cell offset of a piece; code 15 yields no cell.
module piece_cell_rom
  import tetris_pkg::*;
(
  input  logic [3:0] i_piece,
  input  logic [1:0] i_k,
  output logic [1:0] o_dy,
  output logic [1:0] o_dx,
  output logic       o_valid
);

  logic [15:0] w_entry;
  logic [3:0]  w_cell;

  // Select the piece word, then the k-th nibble of it.
  always_comb begin
    w_entry = '0;
    o_valid = 1'b0;
    if (i_piece != 4'd15) begin
      w_entry = PIECE_CELLS[i_piece];
      o_valid = 1'b1;
    end
    w_cell = w_entry[i_k*4 +: 4];
    o_dy   = w_cell[3:2];
    o_dx   = w_cell[1:0];
  end

endmodule

// File: rtl/piece_lock_writer.sv
// Commits a locked piece into the board, then clears full rows by compacting
// the board downward in one bottom-to-top pass and zero-filling the top.
//
// Handshake: lock_req is a single-cycle request honoured only while busy is
// low; busy rises the cycle after accept and stays high through the DONE
// cycle, where done pulses once with lines_cleared valid. Requests seen while
// busy are dropped, never queued.
module piece_lock_writer
  import tetris_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             lock_req,
  input  logic [3:0]       piece,
  input  logic [3:0]       xpos,
  input  logic [4:0]       ypos,
  input  logic [CW-1:0]    color,
  output logic             busy,
  output logic             done,
  output logic [2:0]       lines_cleared,
  output logic             cell_we,
  output logic [4:0]       cell_row,
  output logic [3:0]       cell_col,
  output logic [CW-1:0]    cell_data,
  output logic [4:0]       rd_row,
  input  logic [ROW_W-1:0] rd_data,
  output logic             row_we,
  output logic [4:0]       row_idx,
  output logic [ROW_W-1:0] row_data,
  output lock_state_e      state_dbg
);

  lock_state_e r_state, w_state_nxt;

  logic [3:0]    r_piece;
  logic [3:0]    r_x;
  logic [4:0]    r_y;
  logic [CW-1:0] r_color;
  logic [1:0]    r_k;
  logic [4:0]    r_src;
  logic [4:0]    r_dst;
  logic [4:0]    r_cleared;
  logic [2:0]    r_lines;

  logic [1:0] w_dy, w_dx;
  logic       w_valid;
  logic [5:0] w_row, w_col;
  logic       w_cell_ok;
  logic       w_full;

  piece_cell_rom u_rom (
    .i_piece (r_piece),
    .i_k     (r_k),
    .o_dy    (w_dy),
    .o_dx    (w_dx),
    .o_valid (w_valid)
  );

  // Board coordinates are formed at 6 bits so off-board cells are detectable.
  assign w_row     = {1'b0, r_y} + {4'b0, w_dy};
  assign w_col     = {2'b0, r_x} + {4'b0, w_dx};
  assign w_cell_ok = w_valid && (w_row < 6'(ROWS)) && (w_col < 6'(COLS));
  assign w_full    = row_full(rd_data);
  assign state_dbg = r_state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and all strobes; everything is quiet outside its own phase.
  always_comb begin
    w_state_nxt   = r_state;
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    lines_cleared = r_lines;
    cell_we       = 1'b0;
    cell_row      = '0;
    cell_col      = '0;
    cell_data     = '0;
    rd_row        = '0;
    row_we        = 1'b0;
    row_idx       = '0;
    row_data      = '0;
    case (r_state)
      S_IDLE: begin
        if (lock_req) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        cell_we   = w_cell_ok;
        cell_row  = w_row[4:0];
        cell_col  = w_col[3:0];
        cell_data = r_color;
        if (r_k == 2'd3) w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
        rd_row = r_src;
        // A surviving row only moves when a full row has been dropped below it.
        if (!w_full && (r_dst != r_src)) begin
          row_we   = 1'b1;
          row_idx  = r_dst;
          row_data = rd_data;
        end
        if (r_src == 5'd0) begin
          w_state_nxt = ((r_cleared != 5'd0) || w_full) ? S_FILL : S_DONE;
        end
      end
      S_FILL: begin
        // After the pass dst equals cleared-1, so fill ends exactly at row 0.
        row_we  = 1'b1;
        row_idx = r_dst;
        if (r_dst == 5'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done          = 1'b1;
        lines_cleared = r_cleared[2:0];
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, cell index, scan pointers and cleared-line counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_piece   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_color   <= '0;
      r_k       <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      r_cleared <= '0;
      r_lines   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lock_req) begin
            r_piece   <= piece;
            r_x       <= xpos;
            r_y       <= ypos;
            r_color   <= color;
            r_k       <= 2'd0;
            r_src     <= 5'(ROWS - 1);
            r_dst     <= 5'(ROWS - 1);
            r_cleared <= 5'd0;
          end
        end
        S_WRITE: r_k <= r_k + 2'd1;
        S_SCAN: begin
          if (w_full) r_cleared <= r_cleared + 5'd1;
          else        r_dst     <= r_dst - 5'd1;
          r_src <= r_src - 5'd1;
        end
        S_FILL: r_dst <= r_dst - 5'd1;
        S_DONE: r_lines <= r_cleared[2:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_lock_writer.sv
// Bench for piece_lock_writer: a behavioural board store plus a reference
// model that places the piece and drops full rows with plain array logic.
module tb_piece_lock_writer;

  localparam int NR = 20;
  localparam int NC = 16;
  localparam int W  = 48;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lock_req = 1'b0;
  logic [3:0]   piece = '0;
  logic [3:0]   xpos = '0;
  logic [4:0]   ypos = '0;
  logic [2:0]   color = '0;
  logic         busy, done, cell_we, row_we;
  logic [2:0]   lines_cleared;
  logic [4:0]   cell_row, rd_row, row_idx;
  logic [3:0]   cell_col;
  logic [2:0]   cell_data;
  logic [W-1:0] rd_data, row_data;
  tetris_pkg::lock_state_e state_dbg;

  logic [W-1:0] board     [NR];
  logic [W-1:0] init_board[NR];
  logic [W-1:0] exp_board [NR];
  logic         load_req = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Piece shapes as (dy,dx) lists, cell order k = 0..3.
  int tdy [15][4] = '{'{3,3,3,3}, '{0,1,2,3}, '{2,2,3,3}, '{2,2,3,3}, '{1,2,2,3},
                      '{2,3,3,3}, '{1,1,2,3}, '{2,2,2,3}, '{1,2,3,3},
                      '{2,3,3,3}, '{1,2,2,3}, '{2,2,2,3}, '{1,2,2,3},
                      '{2,2,3,3}, '{1,2,2,3}};
  int tdx [15][4] = '{'{0,1,2,3}, '{1,1,1,1}, '{1,2,1,2}, '{1,2,0,1}, '{0,0,1,1},
                      '{0,0,1,2}, '{1,2,1,1}, '{0,1,2,2}, '{1,1,0,1},
                      '{1,0,1,2}, '{1,1,2,1}, '{0,1,2,1}, '{1,0,1,1},
                      '{0,1,1,2}, '{1,0,1,0}};

  piece_lock_writer dut (
    .clk(clk), .rst(rst), .lock_req(lock_req), .piece(piece), .xpos(xpos),
    .ypos(ypos), .color(color), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .cell_we(cell_we), .cell_row(cell_row),
    .cell_col(cell_col), .cell_data(cell_data), .rd_row(rd_row),
    .rd_data(rd_data), .row_we(row_we), .row_idx(row_idx),
    .row_data(row_data), .state_dbg(state_dbg)
  );

  // Clock and board storage (stands in for the top-level register array).
  always #5 clk = ~clk;

  assign rd_data = (rd_row < 5'd20) ? board[rd_row] : '0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int r = 0; r < NR; r++) board[r] <= init_board[r];
    end else begin
      if (cell_we && cell_row < 5'd20) board[cell_row][int'(cell_col)*3 +: 3] <= cell_data;
      if (row_we && row_idx < 5'd20) board[row_idx] <= row_data;
    end
  end

  function automatic bit is_full(input logic [W-1:0] row);
    for (int c = 0; c < NC; c++) if (row[c*3 +: 3] == 3'b000) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] rand_row(input bit full);
    logic [W-1:0] row;
    for (int c = 0; c < NC; c++)
      row[c*3 +: 3] = full ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7));
    if (!full) row[$urandom_range(0, NC-1)*3 +: 3] = 3'b000;
    return row;
  endfunction

  // Rows above 'top' empty, the rest random; pfull percent of them full.
  task automatic gen_board(input int top, input int pfull);
    for (int r = 0; r < NR; r++)
      init_board[r] = (r < top) ? '0 : rand_row($urandom_range(0, 99) < pfull);
  endtask

  // Reference: drop the in-bounds cells in, keep non-full rows bottom-up,
  // pad the top with empty rows.
  task automatic model_lock(input int p, input int x, input int y, input logic [2:0] col,
                            output int exp_lines, output int exp_cells);
    logic [W-1:0] tmp [NR];
    logic [W-1:0] exp_q [$];
    for (int r = 0; r < NR; r++) tmp[r] = init_board[r];
    exp_cells = 0;
    if (p < 15) begin
      for (int k = 0; k < 4; k++) begin
        int r, c;
        r = y + tdy[p][k];
        c = x + tdx[p][k];
        if (r < NR && c < NC) begin
          tmp[r][c*3 +: 3] = col;
          exp_cells++;
        end
      end
    end
    for (int r = NR-1; r >= 0; r--) if (!is_full(tmp[r])) exp_q.push_back(tmp[r]);
    exp_lines = NR - exp_q.size();
    for (int i = 0; i < NR; i++) exp_board[NR-1-i] = (i < exp_q.size()) ? exp_q[i] : '0;
  endtask

  function automatic int board_diff();
    int n;
    n = 0;
    for (int r = 0; r < NR; r++) if (board[r] !== exp_board[r]) n++;
    return n;
  endfunction

  // Load init_board, issue one lock, follow it to done (bounded). With poke
  // set, extra lock_req pulses with scrambled inputs are thrown in while busy.
  task automatic run_lock(input int p, input int x, input int y, input logic [2:0] col,
                          input bit poke, output int lat, output int lines,
                          output int ncell, output int nover);
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    piece = 4'(p); xpos = 4'(x); ypos = 5'(y); color = col;
    lock_req = 1'b1;
    @(posedge clk); #1;
    lock_req = 1'b0;
    lat = 1; ncell = 0; nover = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (cell_we === 1'b1) ncell++;
      if (cell_we === 1'b1 && row_we === 1'b1) nover++;
      if (poke && (lat == 3 || lat == 12)) begin
        lock_req = 1'b1;
        piece = 4'($urandom_range(0, 15)); xpos = 4'($urandom); ypos = 5'($urandom);
        color = 3'($urandom);
      end else begin
        lock_req = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    lock_req = 1'b0;
    lines = int'(lines_cleared);
  endtask

  task automatic test_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (cell_we !== 1'b0 || row_we !== 1'b0) begin
      n_bad++; $display("FAIL reset_we got %b%b want 00", cell_we, row_we); end
    n_cmp++; if (lines_cleared !== 3'd0) begin
      n_bad++; $display("FAIL reset_lines got %0d want 0", lines_cleared); end
    n_cmp++; if (state_dbg !== tetris_pkg::S_IDLE) begin
      n_bad++; $display("FAIL reset_state got %0d want IDLE", state_dbg); end
  endtask

  task automatic test_empty_i1();
    int lat, lines, ncell, nover, el, ec;
    for (int r = 0; r < NR; r++) init_board[r] = '0;
    model_lock(0, 0, 16, 3'd3, el, ec);
    run_lock(0, 0, 16, 3'd3, 1'b0, lat, lines, ncell, nover);
    n_cmp++; if (lat !== 25) begin n_bad++; $display("FAIL empty_latency got %0d want 25", lat); end
    n_cmp++; if (lines !== 0) begin n_bad++; $display("FAIL empty_lines got %0d want 0", lines); end
    n_cmp++; if (ncell !== 4) begin n_bad++; $display("FAIL empty_cells got %0d want 4", ncell); end
    n_cmp++; if (board[19] !== 48'h6DB) begin
      n_bad++; $display("FAIL empty_row19 got %h want %h", board[19], 48'h6DB); end
    n_cmp++; if (board_diff() !== 0) begin n_bad++; $display("FAIL empty_board got %0d bad rows want 0", board_diff()); end
  endtask

  task automatic test_one_line();
    int lat, lines, ncell, nover, el, ec;
    logic [W-1:0] row_a;
    gen_board(10, 0);
    row_a = init_board[18];
    init_board[19] = '0;
    for (int c = 4; c < NC; c++) init_board[19][c*3 +: 3] = 3'd5;
    model_lock(0, 0, 16, 3'd3, el, ec);
    run_lock(0, 0, 16, 3'd3, 1'b0, lat, lines, ncell, nover);
    n_cmp++; if (lat !== 26) begin n_bad++; $display("FAIL one_latency got %0d want 26", lat); end
    n_cmp++; if (lines !== 1) begin n_bad++; $display("FAIL one_lines got %0d want 1", lines); end
    n_cmp++; if (board[19] !== row_a) begin
      n_bad++; $display("FAIL one_row19 got %h want %h", board[19], row_a); end
    n_cmp++; if (board[0] !== '0) begin n_bad++; $display("FAIL one_row0 got %h want 0", board[0]); end
    n_cmp++; if (board_diff() !== 0) begin n_bad++; $display("FAIL one_board got %0d bad rows want 0", board_diff()); end
  endtask

  task automatic test_four_lines();
    int lat, lines, ncell, nover, el, ec;
    logic [W-1:0] row15;
    gen_board(8, 0);
    for (int r = 16; r < NR; r++) begin
      init_board[r] = rand_row(1'b1);
      init_board[r][3 +: 3] = 3'b000;
    end
    row15 = init_board[15];
    model_lock(1, 0, 16, 3'd2, el, ec);
    run_lock(1, 0, 16, 3'd2, 1'b0, lat, lines, ncell, nover);
    n_cmp++; if (lat !== 29) begin n_bad++; $display("FAIL four_latency got %0d want 29", lat); end
    n_cmp++; if (lines !== 4) begin n_bad++; $display("FAIL four_lines got %0d want 4", lines); end
    n_cmp++; if (board[19] !== row15) begin
      n_bad++; $display("FAIL four_row19 got %h want %h", board[19], row15); end
    n_cmp++; if (nover !== 0) begin n_bad++; $display("FAIL four_overlap got %0d want 0", nover); end
    n_cmp++; if (board_diff() !== 0) begin n_bad++; $display("FAIL four_board got %0d bad rows want 0", board_diff()); end
  endtask

  task automatic test_two_lines();
    int lat, lines, ncell, nover, el, ec;
    logic [W-1:0] row_a, row_b;
    for (int r = 0; r < 16; r++) init_board[r] = '0;
    row_a = rand_row(1'b0);
    row_b = rand_row(1'b0);
    init_board[19] = rand_row(1'b1);
    init_board[18] = row_a;
    init_board[17] = rand_row(1'b1);
    init_board[16] = row_b;
    model_lock(2, 6, 0, 3'd4, el, ec);
    run_lock(2, 6, 0, 3'd4, 1'b0, lat, lines, ncell, nover);
    n_cmp++; if (lines !== 2) begin n_bad++; $display("FAIL two_lines got %0d want 2", lines); end
    n_cmp++; if (lat !== 27) begin n_bad++; $display("FAIL two_latency got %0d want 27", lat); end
    n_cmp++; if (board[19] !== row_a || board[18] !== row_b) begin
      n_bad++; $display("FAIL two_rows got %h/%h want %h/%h", board[19], board[18], row_a, row_b); end
    n_cmp++; if (board_diff() !== 0) begin n_bad++; $display("FAIL two_board got %0d bad rows want 0", board_diff()); end
  endtask

  task automatic test_invalid_and_edge();
    int lat, lines, ncell, nover, el, ec;
    gen_board(12, 0);
    model_lock(15, 3, 10, 3'd6, el, ec);
    run_lock(15, 3, 10, 3'd6, 1'b0, lat, lines, ncell, nover);
    n_cmp++; if (ncell !== 0) begin n_bad++; $display("FAIL invalid_cells got %0d want 0", ncell); end
    n_cmp++; if (lat !== 25 || lines !== 0) begin
      n_bad++; $display("FAIL invalid_done got lat %0d lines %0d want 25 0", lat, lines); end
    n_cmp++; if (board_diff() !== 0) begin n_bad++; $display("FAIL invalid_board got %0d bad rows want 0", board_diff()); end
    gen_board(14, 0);
    model_lock(2, 14, 8, 3'd7, el, ec);
    run_lock(2, 14, 8, 3'd7, 1'b0, lat, lines, ncell, nover);
    n_cmp++; if (ncell !== 2) begin n_bad++; $display("FAIL edge_cells got %0d want 2", ncell); end
    n_cmp++; if (board_diff() !== 0) begin n_bad++; $display("FAIL edge_board got %0d bad rows want 0", board_diff()); end
  endtask

  task automatic test_reset_mid();
    gen_board(10, 30);
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    piece = 4'd0; xpos = 4'd0; ypos = 5'd16; color = 3'd1; lock_req = 1'b1;
    @(posedge clk); #1;
    lock_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_busy_done got %b%b want 00", busy, done); end
    n_cmp++; if (cell_we !== 1'b0 || row_we !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_we got %b%b want 00", cell_we, row_we); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_after_busy got %b want 0", busy); end
  endtask

  task automatic test_busy_ignore();
    int lat, lines, ncell, nover, el, ec;
    gen_board(8, 25);
    init_board[19] = '1;
    init_board[19][0 +: 3] = 3'b000;
    model_lock(0, 0, 16, 3'd5, el, ec);
    run_lock(0, 0, 16, 3'd5, 1'b1, lat, lines, ncell, nover);
    n_cmp++; if (lat !== 25 + el) begin n_bad++; $display("FAIL busy_latency got %0d want %0d", lat, 25 + el); end
    n_cmp++; if (lines !== el) begin n_bad++; $display("FAIL busy_lines got %0d want %0d", lines, el); end
    n_cmp++; if (board_diff() !== 0) begin n_bad++; $display("FAIL busy_board got %0d bad rows want 0", board_diff()); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_requeue got %b want 0", busy); end
  endtask

  task automatic test_random();
    int lat, lines, ncell, nover, el, ec, p, x, y;
    logic [2:0] col;
    for (int it = 0; it < 12; it++) begin
      gen_board($urandom_range(4, 16), 15);
      p = $urandom_range(0, 15);
      x = $urandom_range(0, 15);
      y = $urandom_range(10, 19);
      col = 3'($urandom_range(0, 7));
      model_lock(p, x, y, col, el, ec);
      run_lock(p, x, y, col, 1'b0, lat, lines, ncell, nover);
      n_cmp++; if (lat !== 25 + el || lines !== (el & 7)) begin
        n_bad++; $display("FAIL rand%0d_done got lat %0d lines %0d want %0d %0d", it, lat, lines, 25 + el, el & 7); end
      n_cmp++; if (ncell !== ec || nover !== 0) begin
        n_bad++; $display("FAIL rand%0d_cells got %0d overlap %0d want %0d 0", it, ncell, nover, ec); end
      n_cmp++; if (board_diff() !== 0) begin
        n_bad++; $display("FAIL rand%0d_board got %0d bad rows want 0", it, board_diff()); end
    end
  endtask

  initial begin
    for (int r = 0; r < NR; r++) init_board[r] = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_empty_i1();
    test_one_line();
    test_four_lines();
    test_two_lines();
    test_invalid_and_edge();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piece_lock_writer.md
Name: piece_lock_writer

Overview:
- Write-side counterpart of the move-down collision check. When the active piece can no longer fall, this block commits its four cells into the 20x16 game board.
- It then scans the board for full rows, compacts the board downward in one pass, and reports how many lines were cleared.
- Sits between the game-control FSM (issues lock_req) and the top-level board register array (owns storage and exposes a combinational row-read port plus cell and row write ports).

Parameters:
- ROWS, 20, board rows, row 0 at top.
- COLS, 16, board columns.
- CW, 3, bits per cell; 3'b000 means empty.

Ports:
- Clock  in  1  system clock, posedge.
- Reset  in  1  asynchronous, active-high reset.
- lock_req  in  1  single-cycle request to lock the current piece; sampled only in IDLE.
- piece  in  4  piece/orientation code 0..14 (I1,I2,O,S1,S2,J1..J4,T1..T4,Z1,Z2); 15 is invalid.
- xpos  in  4  left column of the piece's 4x4 box.
- ypos  in  5  top row of the piece's 4x4 box.
- color  in  3  cell value to write.
- busy  out  1  high from the cycle after accept through the DONE cycle.
- done  out  1  one-cycle pulse at completion.
- lines_cleared  out  3  count 0..4; valid while done is high, held until the next accept.
- cell_we  out  1  cell write strobe.
- cell_row  out  5  row of the cell write.
- cell_col  out  4  column of the cell write.
- cell_data  out  3  value of the cell write.
- rd_row  out  5  row-read address.
- rd_data  in  48  combinational row contents; column c occupies bits [3c+2:3c].
- row_we  out  1  whole-row write strobe.
- row_idx  out  5  row written by row_we.
- row_data  out  48  row write data, same packing as rd_data.

Behaviour:
- Reset (async): state=IDLE. All outputs 0, counters 0.
- Accept: lock_req=1 in IDLE latches piece, xpos, ypos, color. Next state is WRITE with k=0.
- WRITE, 4 cycles, k=0..3:
  - Offset (dy,dx) = PIECE_CELLS[piece][k].
  - row = ypos+dy, col = xpos+dx, both computed at 6 bits.
  - cell_we=1 only if row<ROWS and col<COLS; otherwise the cell is silently skipped.
  - piece=15: no cell_we in any of the 4 cycles.
- SCAN, 20 cycles, src=19 down to 0, with dst initialised to 19:
  - rd_row=src. full = all 16 cells of rd_data nonzero.
  - If full: cleared++, dst unchanged, no write.
  - Else: if dst!=src, issue row_we with row_idx=dst, row_data=rd_data. Then dst--.
  - Writes always target rows at or below src that were already read, so no hazard exists. The cell writes from WRITE are visible from the first SCAN cycle.
- FILL, runs only if cleared>0, cleared cycles: row_we with row_idx=dst, row_data=0, dst-- each cycle.
- DONE, 1 cycle: done=1, lines_cleared=cleared, then return to IDLE.
- Total latency from accept edge to done: 4+20+cleared+1 cycles.
- lock_req while busy is ignored; no queueing.
- Only one of cell_we or row_we is asserted in any cycle.
- Reset mid-operation: immediate return to IDLE with outputs 0. A partially written board is the top level's responsibility.
- Cells are written exactly as given; color=0 writes an empty cell.

Decomposition:
- Package tetris_pkg holds:
  - ROWS, COLS and CW.
  - Piece code enum.
  - PIECE_CELLS constant: 15 entries x 4 (dy,dx), 2 bits each, bottom-aligned in the 4x4 box and matching the collision-check geometry. Examples: I1={(3,0),(3,1),(3,2),(3,3)}, I2={(0,1),(1,1),(2,1),(3,1)}, O={(2,1),(2,2),(3,1),(3,2)}.
- One sub-module, piece_cell_rom: combinational lookup from (piece,k) to (dy,dx,valid).

Test Plan:
1. Empty board; I1, x=0, y=16, color=3 -> cell writes to (19,0..3)=3 in cycles 1-4. No row_we. done at cycle 25, lines_cleared=0.
2. Row 19 cols 4..15 prefilled with 5, row 18 = pattern A; I1 at x=0, y=16 -> row 19 full. row_we(19)=A and subsequent rows shift down. FILL writes row 0 = 0. lines_cleared=1, done at cycle 26.
3. Rows 16-19 full except col 1; I2 at x=0, y=16 -> lines_cleared=4. Rows 0-3 zeroed, old row 15 lands at row 19. done at cycle 29.
4. Rows 19 and 17 full, row 18 = A, row 16 = B -> row 19=A, row 18=B. lines_cleared=2.
5. piece=15 -> no cell_we, done at cycle 25, lines_cleared=0. O at x=14 -> only col 15 cells written, col 16 skipped.
6. Assert Reset during SCAN -> busy, done, cell_we and row_we drop to 0 immediately. lock_req pulsed while busy leaves the operation and final results unchanged.
